// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic frame sequencer: pixel width, default
// frame geometry and FSM state encodings.
package bicubic_pkg;

  localparam int PIXEL_W        = 24;
  localparam int PERF_W         = 32;
  localparam int SRC_IMG_WIDTH  = 960;
  localparam int SRC_IMG_HEIGHT = 540;

  // state     | meaning
  // IDLE      | waiting for start
  // ACTIVE    | forwarding source pixels
  // FLUSH     | emitting pad rows to drain core line buffers
  // DONE_WAIT | last beat loaded, waiting for its handshake
  // DONE      | one-cycle done pulse
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACTIVE    = 3'd1;
  localparam logic [2:0] ST_FLUSH     = 3'd2;
  localparam logic [2:0] ST_DONE_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == ST_ACTIVE) || (st == ST_FLUSH) || (st == ST_DONE_WAIT);
  endfunction

endpackage

// File: rtl/bicubic_perf_cnt.sv
// Saturating event counter with synchronous clear; used for the optional
// performance counters of the frame sequencer.
module bicubic_perf_cnt
  import bicubic_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [PERF_W-1:0] o_cnt
);

  logic [PERF_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bicubic_frame_ctrl.sv
// Frame sequencer feeding the bicubic core: forwards one source frame, tags
// sof/eol/eof, appends pad rows. Optional perf counters: BICUBIC_FRAME_CTRL_PERF_EN.
module bicubic_frame_ctrl
  import bicubic_pkg::*;
#(
  parameter int                  SRC_WIDTH   = SRC_IMG_WIDTH,
  parameter int                  SRC_HEIGHT  = SRC_IMG_HEIGHT,
  parameter int                  FLUSH_LINES = 2,
  parameter logic [PIXEL_W-1:0]  PAD_PIXEL   = 24'h000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIXEL_W-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] m_data,
  output logic               m_sof,
  output logic               m_eol,
  output logic               m_eof,
  output logic               m_pad,
  output logic               busy,
  output logic               done
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  starve_cnt,
  output logic [PERF_W-1:0]  bp_cnt
`endif
);

  localparam int XW = $clog2(SRC_WIDTH);
  localparam int YW = $clog2(SRC_HEIGHT + FLUSH_LINES + 1);
  localparam logic [XW-1:0] X_LAST     = XW'(SRC_WIDTH - 1);
  localparam logic [YW-1:0] Y_SRC_LAST = YW'(SRC_HEIGHT - 1);
  localparam logic [YW-1:0] Y_EOF      = YW'(SRC_HEIGHT + FLUSH_LINES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic               r_m_valid;
  logic [PIXEL_W-1:0] r_m_data;
  logic               r_sof;
  logic               r_eol;
  logic               r_eof;
  logic               r_pad;

  logic w_load_ok;
  logic w_s_ready;
  logic w_load_src;
  logic w_load_pad;
  logic w_load;
  logic w_x_last;
  logic w_sof;
  logic w_eof;
  logic w_src_last;
  logic w_start_acc;
  logic w_eof_hs;

  assign w_load_ok   = !r_m_valid || m_ready;
  // abort masks s_ready so a pixel offered alongside abort is never consumed
  assign w_s_ready   = (r_state == ST_ACTIVE) && w_load_ok && !abort;
  assign w_load_src  = w_s_ready && s_valid;
  assign w_load_pad  = (r_state == ST_FLUSH) && w_load_ok && !abort;
  assign w_load      = w_load_src || w_load_pad;
  assign w_x_last    = (r_x == X_LAST);
  assign w_sof       = (r_x == '0) && (r_y == '0);
  assign w_eof       = w_x_last && (r_y == Y_EOF);
  assign w_src_last  = w_x_last && (r_y == Y_SRC_LAST);
  assign w_start_acc = (r_state == ST_IDLE) && start && !abort;
  assign w_eof_hs    = r_m_valid && m_ready && r_eof;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_load_src && w_src_last)
          w_state_nxt = (FLUSH_LINES > 0) ? ST_FLUSH : ST_DONE_WAIT;
      end
      ST_FLUSH: begin
        if (w_load_pad && w_eof) w_state_nxt = ST_DONE_WAIT;
      end
      ST_DONE_WAIT: begin
        if (w_eof_hs) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_sof     <= 1'b0;
      r_eol     <= 1'b0;
      r_eof     <= 1'b0;
      r_pad     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (abort) begin
        r_m_valid <= 1'b0;
        r_x       <= '0;
        r_y       <= '0;
      end else begin
        if (w_start_acc) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_load) begin
          if (w_x_last) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        if (w_load) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_load_pad ? PAD_PIXEL : s_data;
          r_sof     <= w_sof;
          r_eol     <= w_x_last;
          r_eof     <= w_eof;
          r_pad     <= w_load_pad;
        end else if (w_load_ok) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_sof   = r_sof;
  assign m_eol   = r_eol;
  assign m_eof   = r_eof;
  assign m_pad   = r_pad;
  assign busy    = state_is_busy(r_state);
  assign done    = (r_state == ST_DONE);

`ifdef BICUBIC_FRAME_CTRL_PERF_EN
  logic w_starve_ev;
  logic w_bp_ev;

  assign w_starve_ev = (r_state == ST_ACTIVE) && w_s_ready && !s_valid;
  assign w_bp_ev     = r_m_valid && !m_ready;

  bicubic_perf_cnt u_starve_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_start_acc),
    .i_en    (w_starve_ev),
    .o_cnt   (starve_cnt)
  );

  bicubic_perf_cnt u_bp_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_start_acc),
    .i_en    (w_bp_ev),
    .o_cnt   (bp_cnt)
  );
`endif

endmodule

// File: tb/tb_bicubic_frame_ctrl.sv
// Directed bench for bicubic_frame_ctrl (4x3 frame): one instance with two
// pad rows, one with none, selected through a small input/output mux.
module tb_bicubic_frame_ctrl;

  typedef struct {
    int sel;
    int f;
    int stall_at;
    int stall_len;
    int gap_at;
    int gap_len;
    bit start_mid;
    int exp_beats;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, s_valid, m_ready;
  logic [23:0] s_data;
  int          sel;
  int          n_checks = 0;
  int          n_err = 0;

  logic        s_ready0, m_valid0, m_sof0, m_eol0, m_eof0, m_pad0, busy0, done0;
  logic        s_ready1, m_valid1, m_sof1, m_eol1, m_eof1, m_pad1, busy1, done1;
  logic [23:0] m_data0, m_data1;
  logic        s_ready, m_valid, m_sof, m_eol, m_eof, m_pad, busy, done;
  logic [23:0] m_data;
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
  logic [31:0] starve0, bp0, starve1, bp1, starve_w, bp_w;
`endif

  bicubic_frame_ctrl #(.SRC_WIDTH(4), .SRC_HEIGHT(3), .FLUSH_LINES(2), .PAD_PIXEL(24'h000000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .abort(abort && sel == 0),
    .s_valid(s_valid && sel == 0), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
    .m_sof(m_sof0), .m_eol(m_eol0), .m_eof(m_eof0), .m_pad(m_pad0),
    .busy(busy0), .done(done0)
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
    , .starve_cnt(starve0), .bp_cnt(bp0)
`endif
  );

  bicubic_frame_ctrl #(.SRC_WIDTH(4), .SRC_HEIGHT(3), .FLUSH_LINES(0), .PAD_PIXEL(24'h000000)) dut_nf (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .abort(abort && sel == 1),
    .s_valid(s_valid && sel == 1), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_sof(m_sof1), .m_eol(m_eol1), .m_eof(m_eof1), .m_pad(m_pad1),
    .busy(busy1), .done(done1)
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
    , .starve_cnt(starve1), .bp_cnt(bp1)
`endif
  );

  always_comb begin
    s_ready = (sel == 1) ? s_ready1 : s_ready0;
    m_valid = (sel == 1) ? m_valid1 : m_valid0;
    m_data  = (sel == 1) ? m_data1  : m_data0;
    m_sof   = (sel == 1) ? m_sof1   : m_sof0;
    m_eol   = (sel == 1) ? m_eol1   : m_eol0;
    m_eof   = (sel == 1) ? m_eof1   : m_eof0;
    m_pad   = (sel == 1) ? m_pad1   : m_pad0;
    busy    = (sel == 1) ? busy1    : busy0;
    done    = (sel == 1) ? done1    : done0;
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
    starve_w = (sel == 1) ? starve1 : starve0;
    bp_w     = (sel == 1) ? bp1     : bp0;
`endif
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {data, sof, eol, eof, pad} for beat k of a 4x3 frame with f pad rows
  function automatic logic [27:0] exp_beat(input int k, input int f);
    int tot;
    logic [23:0] d;
    tot = 4 * (3 + f);
    d = (k < 12) ? 24'(k + 1) : 24'h000000;
    return {d, (k == 0), (k % 4 == 3), (k == tot - 1), (k >= 12)};
  endfunction

  function automatic logic [31:0] out_vec();
    return {m_valid, s_ready, busy, done, m_sof, m_eol, m_eof, m_pad, m_data};
  endfunction

  task automatic run_frame(input vec_t v);
    int beats, pix, done_cnt, stall_cnt, gap_cnt, last_hs, done_cyc;
    bit st_mid, st_done;
    beats = 0; pix = 1; done_cnt = 0; stall_cnt = 0; gap_cnt = 0;
    last_hs = -10; done_cyc = -1; st_mid = 0; st_done = 0;
    sel = v.sel;
    @(negedge clk);
    start = 1; abort = 0; s_valid = 0; m_ready = 1;
    @(negedge clk);
    for (int cyc = 0; cyc < 300; cyc++) begin
      start = 0;
      m_ready = 1;
      if (beats == v.stall_at && m_valid && stall_cnt < v.stall_len) begin
        m_ready = 0;
        stall_cnt++;
      end
      s_data = 24'(pix);
      s_valid = 1;
      if (pix - 1 == v.gap_at && gap_cnt < v.gap_len) begin
        s_valid = 0;
        gap_cnt++;
      end
      if (v.start_mid && beats == 5 && !st_mid) begin start = 1; st_mid = 1; end
      if (v.start_mid && done && !st_done) begin start = 1; st_done = 1; end
      #1;
      if (cyc == 0) chk("busy_after_start", busy, 1);
      if (!m_ready) begin
        chk($sformatf("hold_beat%0d", beats), {m_data, m_sof, m_eol, m_eof, m_pad}, exp_beat(beats, v.f));
        chk("hold_s_ready", s_ready, 0);
      end
      if (m_valid && m_ready) begin
        chk($sformatf("beat%0d", beats), {m_data, m_sof, m_eol, m_eof, m_pad}, exp_beat(beats, v.f));
        beats++;
        last_hs = cyc;
      end
      if (s_valid && s_ready) pix++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("done_latency", cyc - last_hs, 1);
          chk("busy_at_done", busy, 0);
          done_cyc = cyc;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      @(negedge clk);
    end
    chk("beat_count", beats, v.exp_beats);
    chk("pixels_consumed", pix - 1, 12);
    chk("done_count", done_cnt, 1);
    chk("busy_end", busy, 0);
    start = 0;
    s_valid = 0;
  endtask

  task automatic abort_seq();
    int beats, pix, bad;
    bit hit;
    beats = 0; pix = 1; bad = 0; hit = 0;
    sel = 0; m_ready = 1; s_valid = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
    chk("starve_cleared", starve_w, 0);
    chk("bp_cleared", bp_w, 0);
`endif
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      s_data = 24'(pix);
      s_valid = 1;
      if (m_valid && beats == 7) begin
        abort = 1;
        start = 1;
        hit = 1;
      end
      #1;
      if (!hit) begin
        if (m_valid && m_ready) beats++;
        if (s_valid && s_ready) pix++;
        @(negedge clk);
      end
    end
    chk("abort_reached_beat7", hit, 1);
    @(negedge clk);
    abort = 0; start = 0; s_valid = 0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      if (done || busy) bad++;
      @(negedge clk);
    end
    chk("abort_no_done", bad, 0);
  endtask

  task automatic reset_mid_frame();
    sel = 0; m_ready = 1; s_valid = 1;
    @(negedge clk);
    start = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 0;
      s_data = 24'(i + 1);
    end
    rst_n = 0;
    s_valid = 0;
    @(negedge clk);
    chk("reset_mid_frame_outputs", out_vec(), 0);
    rst_n = 1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{sel: 0, f: 2, stall_at: -1, stall_len: 0, gap_at: -1, gap_len: 0, start_mid: 0, exp_beats: 20};
    vecs[1] = '{sel: 0, f: 2, stall_at: 6,  stall_len: 5, gap_at: -1, gap_len: 0, start_mid: 0, exp_beats: 20};
    vecs[2] = '{sel: 0, f: 2, stall_at: -1, stall_len: 0, gap_at: -1, gap_len: 0, start_mid: 1, exp_beats: 20};
    vecs[3] = '{sel: 1, f: 0, stall_at: -1, stall_len: 0, gap_at: -1, gap_len: 0, start_mid: 0, exp_beats: 12};
    vecs[4] = '{sel: 0, f: 2, stall_at: 2,  stall_len: 4, gap_at: 0,  gap_len: 3, start_mid: 0, exp_beats: 20};

    rst_n = 0; start = 0; abort = 0; s_valid = 0; m_ready = 0; s_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_f2", out_vec(), 0);
    sel = 1;
    #1;
    chk("reset_outputs_f0", out_vec(), 0);
    sel = 0;
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);
`ifdef BICUBIC_FRAME_CTRL_PERF_EN
    chk("starve_cnt", starve_w, 3);
    chk("bp_cnt", bp_w, 4);
`endif

    abort_seq();
    run_frame(vecs[0]);
    reset_mid_frame();
    run_frame(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
